// File: rtl/core_boot_loader_pkg.sv
// Shared definitions for the riscv_core boot loader: FSM state encoding and
// the number of bytes that make up one stream word.
package core_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN,
    CHECK,
    LOAD,
    CSUM,
    RUN,
    ERROR
  } boot_state_t;

  localparam int BOOT_LEN_BYTES = 4;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs an accepted byte stream into 32-bit little-endian words; word_valid
// pulses for one cycle after the fourth byte while word holds the result.
module boot_word_assembler
  import core_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift_reg;
  logic        accept;

  assign accept = byte_valid && byte_ready;
  assign word   = shift_reg;

  // Shifting in from the top leaves the first byte in [7:0] after four shifts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && (byte_cnt == 2'(BOOT_LEN_BYTES - 1));
      if (accept) begin
        shift_reg <= {byte_data, shift_reg[31:8]};
        byte_cnt  <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/core_boot_loader.sv
// Boot sequencer: holds riscv_core in reset, loads an image into instruction
// memory, then releases the core. Optional macro: BOOT_LOADER_CHECKSUM_EN.
module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          boot_req,
  output logic                          imem_wr_en,
  output logic [31:0]                   imem_wr_addr,
  output logic [31:0]                   imem_wr_data,
  output logic                          core_rst_n,
  output logic                          busy,
  output logic                          error,
  output logic [$clog2(IMEM_WORDS):0]   words_loaded
);

  localparam int WL_W = $clog2(IMEM_WORDS) + 1;

  boot_state_t state, next_state;
  logic        armed;
  logic [31:0] len_reg;
  logic        reload;
  logic        last_word;
  logic        asm_word_valid;
  logic [31:0] asm_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] csum_reg;
`endif

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload),
    .byte_valid (in_valid),
    .byte_ready (in_ready),
    .byte_data  (in_data),
    .word_valid (asm_word_valid),
    .word       (asm_word)
  );

  assign last_word    = (32'(words_loaded) + 32'd1 == len_reg);
  assign imem_wr_addr = BASE_ADDR + (32'(words_loaded) << 2);
  assign imem_wr_data = asm_word;

  always_ff @(posedge clk) begin
    if (rst) state <= LEN;
    else     state <= next_state;
  end

  // in_ready drops while a completed word is pending so no byte slips past a phase end.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    imem_wr_en = 1'b0;
    core_rst_n = 1'b0;
    busy       = 1'b1;
    error      = 1'b0;
    reload     = 1'b0;
    case (state)
      LEN: begin
        in_ready = armed && !asm_word_valid;
        if (asm_word_valid) next_state = CHECK;
      end
      CHECK: begin
        if (len_reg == 32'd0 || len_reg > 32'(IMEM_WORDS)) next_state = ERROR;
        else                                                 next_state = LOAD;
      end
      LOAD: begin
        in_ready = !(asm_word_valid && last_word);
        if (asm_word_valid) begin
          imem_wr_en = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          if (last_word) next_state = CSUM;
`else
          if (last_word) next_state = RUN;
`endif
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = !asm_word_valid;
        if (asm_word_valid) next_state = (asm_word == csum_reg) ? RUN : ERROR;
      end
`endif
      RUN: begin
        busy       = 1'b0;
        core_rst_n = 1'b1;
        if (boot_req) begin
          next_state = LEN;
          reload     = 1'b1;
        end
      end
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (boot_req) begin
          next_state = LEN;
          reload     = 1'b1;
        end
      end
      default: next_state = LEN;
    endcase
  end

  // armed keeps in_ready low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed        <= 1'b0;
      len_reg      <= 32'd0;
      words_loaded <= '0;
    end else begin
      armed <= 1'b1;
      if (state == LEN && asm_word_valid) len_reg <= asm_word;
      if (reload)          words_loaded <= '0;
      else if (imem_wr_en) words_loaded <= words_loaded + WL_W'(1);
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || reload)   csum_reg <= 32'd0;
    else if (imem_wr_en) csum_reg <= csum_reg ^ asm_word;
  end
`endif

endmodule
